// File: rtl/ipu_button_ctrl.sv
// Button input processing unit: synchronises and debounces nine cell buttons, writes the cell index
// to grid_coord, then raises an interrupt. Define IPU_OCCUPIED_FILTER_EN to ignore already-played cells.
module ipu_button_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] btn,
   input  logic       int_ack,
   input  logic       clr_board,
   output logic       write_en,
   output logic [3:0] coord_out,
   output logic       ipu_int,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_WRITE,
      ST_INT_WAIT,
      ST_RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_CYCLES);

   state_t           r_state;
   state_t           w_nextState;
   logic [8:0]       r_btnMeta;
   logic [8:0]       r_btnS;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nextCnt;
   logic [3:0]       r_idx;
   logic [3:0]       w_nextIdx;
   logic [3:0]       w_btnIdx;
   logic             r_writeEn;
   logic             w_nextWriteEn;
   logic [3:0]       r_coord;
   logic [3:0]       w_nextCoord;
   logic             r_int;
   logic             w_nextInt;
   logic [8:0]       w_capMask;
   logic             w_blocked;
   logic             w_commit;

   // Two-flop synchroniser for the raw asynchronous buttons
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btnMeta <= '0;
         r_btnS    <= '0;
      end else begin
         r_btnMeta <= btn;
         r_btnS    <= r_btnMeta;
      end
   end

   always_comb begin
      w_btnIdx = '0;
      for (int i = 0; i < 9; i++) begin
         if (r_btnS[i]) w_btnIdx = 4'(i);
      end
   end

   assign w_capMask = 9'(1) << r_idx;
   assign w_commit  = (r_state == ST_DEBOUNCE) && (w_nextState == ST_WRITE);

`ifdef IPU_OCCUPIED_FILTER_EN
   logic [8:0] r_occ;
   logic [8:0] w_nextOcc;

   assign w_blocked = |(r_btnS & r_occ);

   // A new-game clear and a commit on the same edge leave the committed cell marked
   always_comb begin
      w_nextOcc = clr_board ? '0 : r_occ;
      if (w_commit) w_nextOcc = w_nextOcc | w_capMask;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_occ <= '0;
      else      r_occ <= w_nextOcc;
   end
`else
   logic w_unusedClr;
   assign w_unusedClr = clr_board;
   assign w_blocked   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_writeEn <= 1'b0;
         r_coord   <= '0;
         r_int     <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_idx     <= w_nextIdx;
         r_writeEn <= w_nextWriteEn;
         r_coord   <= w_nextCoord;
         r_int     <= w_nextInt;
      end
   end

   // Any change of btn_s while debouncing restarts from IDLE, so only a clean press survives
   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextIdx     = r_idx;
      w_nextWriteEn = 1'b0;
      w_nextCoord   = r_coord;
      w_nextInt     = r_int;
      case (r_state)
         ST_IDLE: begin
            if ($onehot(r_btnS) && !w_blocked) begin
               w_nextIdx   = w_btnIdx;
               w_nextCnt   = CNT_W'(1);
               w_nextState = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (r_btnS != w_capMask) begin
               w_nextCnt   = '0;
               w_nextState = ST_IDLE;
            end else if (r_cnt == DEB_TARGET) begin
               w_nextCnt     = '0;
               w_nextWriteEn = 1'b1;
               w_nextCoord   = r_idx;
               w_nextState   = ST_WRITE;
            end else begin
               w_nextCnt = r_cnt + CNT_W'(1);
            end
         end
         ST_WRITE: begin
            w_nextInt   = 1'b1;
            w_nextState = ST_INT_WAIT;
         end
         ST_INT_WAIT: begin
            w_nextInt = 1'b1;
            if (int_ack) begin
               w_nextInt   = 1'b0;
               w_nextState = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (r_btnS == '0) w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
            w_nextCnt   = '0;
            w_nextInt   = 1'b0;
         end
      endcase
   end

   assign write_en  = r_writeEn;
   assign coord_out = r_coord;
   assign ipu_int   = r_int;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ipu_button_ctrl.sv
// Self-checking bench for ipu_button_ctrl: vector table, hand-written corner sequences and a
// randomized run against a timestamp-based press model. Honours IPU_OCCUPIED_FILTER_EN when defined.
module tb_ipu_button_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [8:0] btn = '0;
   logic       intAck = 1'b0;
   logic       clrBoard = 1'b0;
   logic       writeEn, ipuInt, busy;
   logic [3:0] coordOut;
   logic       writeEn1, ipuInt1, busy1;
   logic [3:0] coordOut1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ipu_button_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .btn(btn), .int_ack(intAck), .clr_board(clrBoard),
      .write_en(writeEn), .coord_out(coordOut), .ipu_int(ipuInt), .busy(busy)
   );

   ipu_button_ctrl #(.DEBOUNCE_CYCLES(1), .CNT_W(16)) dutFast (
      .clk(clk), .rst(rst), .btn(btn), .int_ack(intAck), .clr_board(clrBoard),
      .write_en(writeEn1), .coord_out(coordOut1), .ipu_int(ipuInt1), .busy(busy1)
   );

   // Press model: a press is accepted once the synchronised buttons show the same single cell
   // for D+1 consecutive sampled edges, counted from the edge it was first seen while armed
   localparam int ARMED = 0, SETTLING = 1, STROBED = 2, REQUESTING = 3, DRAINING = 4;
   logic [8:0] mSync[$];
   int         mPhase;
   int         mEdge;
   int         mStart;
   logic [8:0] mCap;
   logic       mWe;
   logic       mInt;
   logic [3:0] mCoord;
   logic [8:0] mOcc;

   task automatic modelReset();
      mSync  = {9'h000, 9'h000};
      mPhase = ARMED;
      mEdge  = 0;
      mStart = 0;
      mCap   = '0;
      mWe    = 1'b0;
      mInt   = 1'b0;
      mCoord = '0;
      mOcc   = '0;
   endtask

   task automatic modelEdge(input logic [8:0] b, input logic a, input logic c);
      logic [8:0] seen;
      logic       taken;
      seen = mSync.pop_front();
      mSync.push_back(b);
      mEdge++;
      mWe = 1'b0;
`ifdef IPU_OCCUPIED_FILTER_EN
      if (c) mOcc = '0;
      taken = |(seen & mOcc);
`else
      taken = 1'b0;
      if (c) taken = 1'b0;
`endif
      case (mPhase)
         ARMED: begin
            if ($countones(seen) == 1 && !taken) begin
               mPhase = SETTLING;
               mCap   = seen;
               mStart = mEdge;
            end
         end
         SETTLING: begin
            if (seen != mCap) mPhase = ARMED;
            else if (mEdge - mStart == D) begin
               mWe    = 1'b1;
               mCoord = 4'($clog2(mCap));
               mPhase = STROBED;
`ifdef IPU_OCCUPIED_FILTER_EN
               mOcc = mOcc | mCap;
`endif
            end
         end
         STROBED: begin
            mInt   = 1'b1;
            mPhase = REQUESTING;
         end
         REQUESTING: begin
            if (a) begin
               mInt   = 1'b0;
               mPhase = DRAINING;
            end
         end
         default: begin
            if (seen == '0) mPhase = ARMED;
         end
      endcase
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after a rising edge; outputs are read 1ns after the next one
   task automatic applyStimulus(input logic [8:0] b, input logic a, input logic c);
      btn = b;
      intAck = a;
      clrBoard = c;
      @(posedge clk);
      if (rst) modelEdge(b, a, c);
      else modelReset();
      #1;
   endtask

   task automatic doReset();
      rst = 1'b0;
      btn = '0;
      intAck = 1'b0;
      clrBoard = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic pressCell(input logic [8:0] b, input int cycles, output int writes,
                            output logic [3:0] lastCoord, output logic sawBusy);
      writes = 0;
      lastCoord = '0;
      sawBusy = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(b, 1'b0, 1'b0);
         if (writeEn) begin
            writes++;
            lastCoord = coordOut;
         end
         if (busy) sawBusy = 1'b1;
      end
   endtask

   typedef struct {
      logic [8:0] btn;
      logic       ack;
      logic       expWe;
      logic [3:0] expCoord;
      logic       expInt;
      logic       expBusy;
      logic       expWe1;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int         cnt;
      int         pulses;
      int         weAt;
      int         intAt;
      int         writes;
      logic       found;
      logic       flag;
      logic       flag2;
      logic [3:0] weCoord;
      logic [8:0] curBtn;
      logic       rAck;
      logic       rClr;
      int         pick;

      vecs[0]  = '{9'h010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{9'h010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{9'h010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{9'h010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{9'h010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{9'h010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{9'h010, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{9'h010, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{9'h010, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{9'h010, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{9'h010, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{9'h000, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{9'h000, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{9'h000, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{9'h000, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};

      $display("[TB] reset state");
      doReset();
      checkOutput("rstWe", writeEn, 0);
      checkOutput("rstCoord", coordOut, 0);
      checkOutput("rstInt", ipuInt, 0);
      checkOutput("rstBusy", busy, 0);

      $display("[TB] vector table: single press of cell 4");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].btn, vecs[i].ack, 1'b0);
         checkOutput($sformatf("vec%0d_we", i), writeEn, vecs[i].expWe);
         checkOutput($sformatf("vec%0d_coord", i), coordOut, vecs[i].expCoord);
         checkOutput($sformatf("vec%0d_int", i), ipuInt, vecs[i].expInt);
         checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
         checkOutput($sformatf("vec%0d_weFast", i), writeEn1, vecs[i].expWe1);
      end

      $display("[TB] reset in the middle of debounce");
      for (int i = 0; i < 4; i++) applyStimulus(9'h040, 1'b0, 1'b0);
      checkOutput("midBusy", busy, 1);
      checkOutput("midCoordBefore", coordOut, 4);
      #2 rst = 1'b0;
      modelReset();
      #1;
      checkOutput("midRstWe", writeEn, 0);
      checkOutput("midRstCoord", coordOut, 0);
      checkOutput("midRstInt", ipuInt, 0);
      checkOutput("midRstBusy", busy, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      cnt = 0;
      found = 1'b0;
      while (!found && cnt < 30) begin
         applyStimulus(9'h040, 1'b0, 1'b0);
         cnt++;
         if (writeEn) found = 1'b1;
      end
      checkOutput("midWriteFound", found, 1);
      checkOutput("midLatency", cnt, 7);
      checkOutput("midCoord", coordOut, 6);

      $display("[TB] bounce on cell 2");
      doReset();
      pulses = 0;
      weAt = 0;
      intAt = 0;
      weCoord = '0;
      for (int c = 1; c <= 20; c++) begin
         applyStimulus((c == 4) ? 9'h000 : 9'h004, 1'b0, 1'b0);
         if (writeEn) begin
            pulses++;
            if (weAt == 0) weAt = c;
            weCoord = coordOut;
         end
         if (ipuInt && intAt == 0) intAt = c;
      end
      checkOutput("bouncePulses", pulses, 1);
      checkOutput("bounceWeCycle", weAt, 11);
      checkOutput("bounceCoord", weCoord, 2);
      checkOutput("bounceIntCycle", intAt, 12);

      $display("[TB] two buttons at once");
      doReset();
      flag = 1'b0;
      flag2 = 1'b0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(9'h003, 1'b0, 1'b0);
         if (writeEn) pulses++;
         if (ipuInt) flag = 1'b1;
         if (busy) flag2 = 1'b1;
      end
      checkOutput("twoBtnWrites", pulses, 0);
      checkOutput("twoBtnInt", flag, 0);
      checkOutput("twoBtnBusy", flag2, 0);

      $display("[TB] interrupt handshake");
      doReset();
      cnt = 0;
      found = 1'b0;
      while (!found && cnt < 30) begin
         applyStimulus(9'h100, 1'b0, 1'b0);
         cnt++;
         if (ipuInt) found = 1'b1;
      end
      checkOutput("hsIntFound", found, 1);
      checkOutput("hsCoord", coordOut, 8);
      flag = 1'b1;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(9'h100, 1'b0, 1'b0);
         if (!ipuInt) flag = 1'b0;
      end
      checkOutput("hsIntHeld", flag, 1);
      applyStimulus(9'h100, 1'b1, 1'b0);
      checkOutput("hsIntDrop", ipuInt, 0);
      pressCell(9'h100, 10, writes, weCoord, flag);
      checkOutput("hsHeldNoWrite", writes, 0);
      checkOutput("hsHeldBusy", busy, 1);
      checkOutput("hsHeldNoInt", ipuInt, 0);
      for (int c = 0; c < 4; c++) applyStimulus(9'h000, 1'b0, 1'b0);
      checkOutput("hsReleasedIdle", busy, 0);
      pressCell(9'h100, 20, writes, weCoord, flag);
      checkOutput("hsRepressWrites", writes, 1);
      checkOutput("hsRepressCoord", weCoord, 8);

      $display("[TB] repeated press of cell 5 and board clear");
      doReset();
      pressCell(9'h020, 20, writes, weCoord, flag);
      checkOutput("occFirstWrites", writes, 1);
      checkOutput("occFirstCoord", weCoord, 5);
      applyStimulus(9'h020, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(9'h000, 1'b0, 1'b0);
      pressCell(9'h020, 20, writes, weCoord, flag);
`ifdef IPU_OCCUPIED_FILTER_EN
      checkOutput("occSecondWrites", writes, 0);
      checkOutput("occSecondBusy", flag, 0);
`else
      checkOutput("occSecondWrites", writes, 1);
      checkOutput("occSecondCoord", weCoord, 5);
`endif
      applyStimulus(9'h020, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(9'h000, 1'b0, 1'b0);
      applyStimulus(9'h000, 1'b0, 1'b1);
      checkOutput("clrBusy", busy, 0);
      checkOutput("clrInt", ipuInt, 0);
      checkOutput("clrCoord", coordOut, 5);
      pressCell(9'h020, 20, writes, weCoord, flag);
      checkOutput("clrPressWrites", writes, 1);
      checkOutput("clrPressCoord", weCoord, 5);

      $display("[TB] randomized run against model");
      doReset();
      curBtn = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 11) == 0) begin
            pick = $urandom_range(0, 9);
            if (pick < 2) curBtn = '0;
            else if (pick < 8) curBtn = 9'(1) << $urandom_range(0, 8);
            else curBtn = (9'(1) << $urandom_range(0, 8)) | (9'(1) << $urandom_range(0, 8));
         end
         rAck = ($urandom_range(0, 5) == 0);
         rClr = ($urandom_range(0, 19) == 0);
         applyStimulus(curBtn, rAck, rClr);
         checkOutput("rndWe", writeEn, mWe);
         checkOutput("rndCoord", coordOut, mCoord);
         checkOutput("rndInt", ipuInt, mInt);
         checkOutput("rndBusy", busy, (mPhase != ARMED));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
